// File: rtl/activity_load_gen.sv
// activity_load_gen
// Switching-activity load generator. A bank of SRC_W source bits, each
// replicated REP times, drives a registered load bus for a programmed number
// of cycles. Sources: zero, static pattern, pattern XOR Fibonacci LFSR, or
// pattern / inverse-pattern alternation. Configured through one valid/ready
// command port, accepted only while idle.
//
// Optional feature macro: ACTIVITY_ABORT_EN
//   defined   : abort sampled high in RUN ends the run early (normal DONE follows)
//   undefined : the abort port exists but has no effect
module activity_load_gen #(
  parameter int                   SRC_W   = 8,
  parameter int                   REP     = 8,
  parameter int                   LFSR_W  = 20,
  parameter logic [LFSR_W-1:0]    TAPS    = 20'h90000,
  parameter int                   DWELL_W = 16,
  localparam int                  LOAD_W  = SRC_W * REP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [SRC_W-1:0]    cfg_pattern,
  input  logic [LFSR_W-1:0]   cfg_seed,
  input  logic [DWELL_W-1:0]  cfg_dwell,
  input  logic                abort,
  output logic [LOAD_W-1:0]   load,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ZERO   = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_LFSR   = 2'd2;
  localparam logic [1:0] MODE_ALT    = 2'd3;

  // Feedback bit of the Fibonacci LFSR: parity of the tapped bits.
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] v);
    return ^(v & TAPS);
  endfunction

  // Fan each source bit out to REP adjacent load bits.
  function automatic logic [LOAD_W-1:0] replicate(input logic [SRC_W-1:0] s);
    logic [LOAD_W-1:0] r;
    r = {LOAD_W{1'b0}};
    for (int i = 0; i < SRC_W; i++) begin
      for (int j = 0; j < REP; j++) begin
        r[i*REP+j] = s[i];
      end
    end
    return r;
  endfunction

  state_t               state_r;
  logic [1:0]           mode_r;
  logic [SRC_W-1:0]     pattern_r;
  logic [LFSR_W-1:0]    lfsr_r;
  logic [DWELL_W-1:0]   cnt_r;
  logic                 odd_r;      // next run cycle is an odd one (1st, 3rd, ...)
  logic [LOAD_W-1:0]    load_r;

  logic [SRC_W-1:0]     src_s;
  logic [LFSR_W-1:0]    lfsr_next_s;
  logic [LFSR_W-1:0]    seed_s;
  logic                 abort_s;
  logic                 last_s;

`ifdef ACTIVITY_ABORT_EN
  assign abort_s = abort;
`else
  logic unused_abort_s;
  assign unused_abort_s = abort;
  assign abort_s        = 1'b0;
`endif

  // A zero seed would lock the LFSR, so it is replaced by 1.
  always_comb begin
    if (cfg_seed == {LFSR_W{1'b0}}) begin
      seed_s = LFSR_W'(1);
    end else begin
      seed_s = cfg_seed;
    end
  end

  // LFSR advance: shift left, feedback into bit 0.
  always_comb begin
    lfsr_next_s = {lfsr_r[LFSR_W-2:0], lfsr_fb(lfsr_r)};
  end

  // Source bit selection from the pre-advance LFSR value.
  always_comb begin
    src_s = {SRC_W{1'b0}};
    case (mode_r)
      MODE_ZERO:   src_s = {SRC_W{1'b0}};
      MODE_STATIC: src_s = pattern_r;
      MODE_LFSR:   src_s = pattern_r ^ lfsr_r[SRC_W-1:0];
      MODE_ALT: begin
        if (odd_r) begin
          src_s = pattern_r;
        end else begin
          src_s = ~pattern_r;
        end
      end
      default:     src_s = {SRC_W{1'b0}};
    endcase
  end

  // Run terminates on the final counted cycle or on an accepted abort.
  always_comb begin
    if ((cnt_r == DWELL_W'(1)) || abort_s) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Control FSM with its datapath registers and the registered load bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      mode_r    <= 2'd0;
      pattern_r <= {SRC_W{1'b0}};
      lfsr_r    <= LFSR_W'(1);
      cnt_r     <= {DWELL_W{1'b0}};
      odd_r     <= 1'b0;
      load_r    <= {LOAD_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          load_r <= {LOAD_W{1'b0}};
          if (cfg_valid) begin
            mode_r    <= cfg_mode;
            pattern_r <= cfg_pattern;
            lfsr_r    <= seed_s;
            cnt_r     <= cfg_dwell;
            odd_r     <= 1'b1;
            if (cfg_dwell == {DWELL_W{1'b0}}) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          load_r <= replicate(src_s);
          lfsr_r <= lfsr_next_s;
          cnt_r  <= cnt_r - DWELL_W'(1);
          odd_r  <= ~odd_r;
          if (last_s) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          load_r  <= {LOAD_W{1'b0}};
          state_r <= ST_IDLE;
        end
        default: begin
          load_r  <= {LOAD_W{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign load      = load_r;
  assign cfg_ready = (state_r == ST_IDLE);
  assign busy      = (state_r == ST_RUN) || (state_r == ST_DONE);
  assign done      = (state_r == ST_DONE);

endmodule

// File: tb/tb_activity_load_gen.sv
// Self-checking bench for activity_load_gen (default parameters).
// Directed test-plan scenarios plus randomized commands checked against a
// behavioural model of the load sequence.
module tb_activity_load_gen;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_pattern;
  logic [19:0] cfg_seed;
  logic [15:0] cfg_dwell;
  logic        abort;
  logic [63:0] load;
  logic        busy;
  logic        done;

  int          n_tests;
  int          n_fail;
  logic [63:0] first_obs;
  logic [63:0] second_obs;

  activity_load_gen dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mode    (cfg_mode),
    .cfg_pattern (cfg_pattern),
    .cfg_seed    (cfg_seed),
    .cfg_dwell   (cfg_dwell),
    .abort       (abort),
    .load        (load),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: one LFSR step, x^20+x^17+1 (taps at bits 19 and 16).
  function automatic logic [19:0] ref_step(input logic [19:0] v);
    int ones;
    ones = $countones(v & 20'h90000);
    return ((v << 1) | 20'(ones % 2)) & 20'hFFFFF;
  endfunction

  // Reference: each source bit set lights its whole byte of the bus.
  function automatic logic [63:0] ref_expand(input logic [7:0] s);
    logic [63:0] e;
    logic [63:0] byte_ones;
    e = 64'd0;
    byte_ones = 64'hFF;
    for (int i = 0; i < 8; i++) begin
      if (s[i]) e = e | (byte_ones << (i * 8));
    end
    return e;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 300; i++) begin
      if (cfg_ready) break;
      @(posedge clk); #1;
    end
    check_eq("ready_wait", {63'd0, cfg_ready}, 64'd1);
  endtask

  task automatic spurious_cfg();
    if ($urandom_range(0, 3) == 0) begin
      cfg_valid   = 1'b1;
      cfg_mode    = 2'($urandom_range(0, 3));
      cfg_pattern = 8'($urandom);
      cfg_seed    = 20'($urandom);
      cfg_dwell   = 16'($urandom_range(0, 5));
    end else begin
      cfg_valid = 1'b0;
    end
  endtask

  // Issue one command and check every cycle until the block is idle again.
  // ab_at: run cycle (1-based) at whose closing edge abort is high; 0 = none.
  task automatic run_cmd(input logic [1:0] m, input logic [7:0] p,
                         input logic [19:0] s, input int d, input int ab_at);
    logic [19:0] lf;
    logic [7:0]  src;
    logic [63:0] exp_load;
    int          eff;
    lf  = (s == 20'd0) ? 20'd1 : s;
    eff = d;
`ifdef ACTIVITY_ABORT_EN
    if (ab_at > 0 && ab_at < d) eff = ab_at;
`endif
    wait_ready();
    @(negedge clk);
    cfg_valid   = 1'b1;
    cfg_mode    = m;
    cfg_pattern = p;
    cfg_seed    = s;
    cfg_dwell   = 16'(d);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check_eq("accept_load", load, 64'd0);
    check_eq("accept_ready", {63'd0, cfg_ready}, 64'd0);
    check_eq("accept_busy", {63'd0, busy}, 64'd1);
    check_eq("accept_done", {63'd0, done}, {63'd0, (eff == 0)});
    for (int k = 1; k <= eff; k++) begin
      abort = (ab_at == k);
      spurious_cfg();
      @(posedge clk); #1;
      abort     = 1'b0;
      cfg_valid = 1'b0;
      case (m)
        2'd0:    src = 8'd0;
        2'd1:    src = p;
        2'd2:    src = p ^ lf[7:0];
        default: src = (k % 2 == 1) ? p : ~p;
      endcase
      lf = ref_step(lf);
      exp_load = ref_expand(src);
      if (k == 1) first_obs = load;
      if (k == 2) second_obs = load;
      check_eq("run_load", load, exp_load);
      check_eq("run_done", {63'd0, done}, {63'd0, (k == eff)});
      check_eq("run_busy", {63'd0, busy}, 64'd1);
      check_eq("run_ready", {63'd0, cfg_ready}, 64'd0);
    end
    abort = $urandom_range(0, 1) == 1;   // abort in DONE must be ignored
    spurious_cfg();
    @(posedge clk); #1;
    abort     = 1'b0;
    cfg_valid = 1'b0;
    check_eq("end_load", load, 64'd0);
    check_eq("end_done", {63'd0, done}, 64'd0);
    check_eq("end_ready", {63'd0, cfg_ready}, 64'd1);
    check_eq("end_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    cfg_valid   = 1'b0;
    cfg_mode    = 2'd0;
    cfg_pattern = 8'd0;
    cfg_seed    = 20'd0;
    cfg_dwell   = 16'd0;
    abort       = 1'b0;
    first_obs   = 64'd0;
    second_obs  = 64'd0;
    #1;
    check_eq("rst_load", load, 64'd0);
    check_eq("rst_ready", {63'd0, cfg_ready}, 64'd1);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed test-plan scenarios.
    run_cmd(2'd1, 8'hA5, 20'h00001, 3, 0);
    check_eq("tp_static_a5", first_obs, 64'hFF00FF0000FF00FF);
    run_cmd(2'd2, 8'h00, 20'h00001, 2, 0);
    check_eq("tp_lfsr_e1", first_obs, 64'h00000000000000FF);
    check_eq("tp_lfsr_e2", second_obs, 64'h000000000000FF00);
    run_cmd(2'd2, 8'h00, 20'h00000, 2, 0);
    check_eq("tp_seed0_e1", first_obs, 64'h00000000000000FF);
    check_eq("tp_seed0_e2", second_obs, 64'h000000000000FF00);
    run_cmd(2'd3, 8'h0F, 20'h00001, 4, 0);
    check_eq("tp_alt_e1", first_obs, 64'h00000000FFFFFFFF);
    check_eq("tp_alt_e2", second_obs, 64'hFFFFFFFF00000000);
    run_cmd(2'd1, 8'hFF, 20'h00001, 0, 0);
    run_cmd(2'd1, 8'h3C, 20'h00001, 100, 5);
    run_cmd(2'd0, 8'hFF, 20'h12345, 3, 0);

    // Asynchronous reset in the middle of a run.
    wait_ready();
    @(negedge clk);
    cfg_valid   = 1'b1;
    cfg_mode    = 2'd1;
    cfg_pattern = 8'hFF;
    cfg_seed    = 20'd1;
    cfg_dwell   = 16'd100;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("prerst_load", load, 64'hFFFFFFFFFFFFFFFF);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_load", load, 64'd0);
    check_eq("arst_ready", {63'd0, cfg_ready}, 64'd1);
    check_eq("arst_done", {63'd0, done}, 64'd0);
    check_eq("arst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("postrst_done", {63'd0, done}, 64'd0);
      check_eq("postrst_load", load, 64'd0);
    end

    // Randomized commands against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  rm;
      logic [7:0]  rp;
      logic [19:0] rs;
      int          rd;
      int          ra;
      rm = 2'($urandom_range(0, 3));
      rp = 8'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom);
      rd = $urandom_range(0, 20);
      ra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 22) : 0;
      run_cmd(rm, rp, rs, rd, ra);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
